pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Next-PC controller for the RISC-V single-cycle core; owns the program counter register and sequences instruction fetch.
- Selects sequential, branch, jump or trap targets, and handles the instruction-memory request/acknowledge handshake, pipeline stall, post-reset boot delay and misaligned-target faults.
- Sits between the execute-stage branch/jump logic and the instruction memory port.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- FAULT_VECTOR, 32'h0000_0100, PC loaded when a redirect target is misaligned.
- BOOT_DELAY, 4, cycles held in BOOT after reset release before the first fetch; 0 to 255.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- stall  in  1  hold request from downstream logic.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  32  branch destination.
- jump  in  1  JAL/JALR redirect.
- jump_target  in  32  jump destination.
- trap  in  1  external trap/interrupt request.
- trap_vector  in  32  trap handler address.
- imem_ack  in  1  instruction memory has data for pc_out this cycle.
- imem_req  out  1  fetch request for address pc_out.
- pc_out  out  32  current PC.
- pc_plus4  out  32  pc_out + 4, combinational, modulo 2^32.
- instr_valid  out  1  fetched instruction is consumed this cycle.
- misaligned  out  1  one-cycle pulse on a misaligned redirect.
- epc_out  out  32  PC captured at the last trap or fault.
- state_out  out  2  BOOT=0, FETCH=1, HOLD=2, FLUSH=3.

Behaviour:
- Reset asserted (reset=0), immediate and asynchronous:
  - pc_out=RESET_VECTOR, epc_out=0, boot counter=0, state=BOOT.
  - imem_req=0, instr_valid=0, misaligned=0.
  - An outstanding request is abandoned.
- imem_req = (state==FETCH). It is combinational from state, so it drops in the same cycle the state leaves FETCH.
- advance = FETCH & imem_ack & ~stall & ~trap. instr_valid = advance (combinational).
- BOOT:
  - Counter increments each cycle; go to FETCH when counter == BOOT_DELAY-1.
  - BOOT_DELAY=0: go to FETCH on the first edge after reset release.
  - trap, stall and redirect inputs are ignored.
- FETCH, priority highest first:
  - trap=1: pc_out<=trap_vector, epc_out<=pc_out, go to FLUSH. Any imem_ack this cycle is discarded.
  - stall=1: go to HOLD; pc_out unchanged; an ack this cycle is discarded and the same PC is refetched later.
  - advance with jump=1: target=jump_target.
  - advance with branch_taken=1 (and jump=0): target=branch_target.
  - advance otherwise: pc_out<=pc_plus4; stay in FETCH.
- Redirect alignment (jump/branch targets only):
  - target[1:0]==0: pc_out<=target; stay in FETCH.
  - target[1:0]!=0: pc_out<=FAULT_VECTOR, epc_out<=pc_out, misaligned=1 for the next cycle, go to FLUSH.
  - trap_vector is not alignment-checked; bits [1:0] are forced to 0 when loaded.
- FETCH with imem_ack=0: hold pc_out. branch_taken and jump are ignored.
- HOLD:
  - imem_req=0.
  - trap=1: same action as in FETCH.
  - stall=0: return to FETCH and re-request the same pc_out.
- FLUSH: exactly one bubble cycle; imem_req=0, instr_valid=0; then FETCH. trap in FLUSH is ignored.
- Wrap-around: pc_plus4 of 32'hFFFF_FFFC is 32'h0000_0000. No flag is raised.
- misaligned is registered: high for exactly one cycle after the faulting edge, otherwise 0.

Test Plan:
- Reset with BOOT_DELAY=4, imem_ack always 1 → imem_req=0 for 4 cycles after release. pc_out then sequences 0x0, 0x4, 0x8 with instr_valid=1 each cycle.
- imem_ack low for 3 cycles at pc_out=0x10 → pc_out holds at 0x10 and instr_valid=0; advances to 0x14 the cycle after ack rises.
- At pc_out=0x20: jump=1 to 0x80 and branch_taken=1 to 0x40 in the same ack cycle → pc_out=0x80. A second case with branch only to 0x40 → pc_out=0x40.
- branch_target=0x42 at pc_out=0x30 → pc_out=0x100, epc_out=0x30, misaligned pulses for 1 cycle, one FLUSH bubble, then a fetch at 0x100.
- Cases covering stall, trap and HOLD:
  - stall=1 for 2 cycles with ack at 0x50 → HOLD, imem_req=0, no advance; 0x50 is refetched afterwards.
  - trap during HOLD with trap_vector=0x200 → pc_out=0x200, epc_out=0x50.
  - trap coincident with stall → trap wins.
- pc_out=0xFFFF_FFFC with an ack → next pc_out=0x0.
- Drop reset mid-fetch → imem_req falls asynchronously and pc_out returns to RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundle of the execute-stage redirect inputs, instruction-memory handshake and PC status
// outputs of the next-PC controller.
interface pc_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        trap;
  logic [31:0] trap_vector;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misaligned;
  logic [31:0] epc_out;
  logic [1:0]  state_out;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, trap, trap_vector, imem_ack,
    input  imem_req, pc_out, pc_plus4, instr_valid, misaligned, epc_out, state_out
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, trap, trap_vector, imem_ack,
    output imem_req, pc_out, pc_plus4, instr_valid, misaligned, epc_out, state_out
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the program counter and sequences fetches through BOOT, FETCH,
// HOLD and FLUSH.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] FAULT_VECTOR = 32'h0000_0100,
  parameter int          BOOT_DELAY   = 4
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  // BOOT_DELAY of 0 and 1 both leave BOOT on the first edge after reset release.
  localparam logic [7:0] BOOT_LAST = (BOOT_DELAY == 0) ? 8'd0 : 8'(BOOT_DELAY - 1);

  logic [1:0]  state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] epc_r, epc_nxt_s;
  logic [7:0]  boot_cnt_r, boot_cnt_nxt_s;
  logic        misaligned_r, misaligned_nxt_s;
  logic        advance_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  assign pc_plus4_s = pc_r + 32'd4;
  assign advance_s  = (state_r == FETCH) & bus.imem_ack & ~bus.stall & ~bus.trap;
  assign target_s   = bus.jump ? bus.jump_target : bus.branch_target;

  // Next-state, next-PC and exception-PC selection.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    epc_nxt_s        = epc_r;
    boot_cnt_nxt_s   = boot_cnt_r;
    misaligned_nxt_s = 1'b0;
    case (state_r)
      BOOT: begin
        if (boot_cnt_r == BOOT_LAST) begin
          state_nxt_s = FETCH;
        end else begin
          boot_cnt_nxt_s = boot_cnt_r + 8'd1;
        end
      end
      FETCH, HOLD: begin
        if (bus.trap) begin
          pc_nxt_s    = {bus.trap_vector[31:2], 2'b00};
          epc_nxt_s   = pc_r;
          state_nxt_s = FLUSH;
        end else if (bus.stall) begin
          state_nxt_s = HOLD;
        end else if (state_r == HOLD) begin
          state_nxt_s = FETCH;
        end else if (!bus.imem_ack) begin
          state_nxt_s = FETCH;
        end else if (bus.jump || bus.branch_taken) begin
          if (is_word_aligned(target_s)) begin
            pc_nxt_s = target_s;
          end else begin
            pc_nxt_s         = FAULT_VECTOR;
            epc_nxt_s        = pc_r;
            misaligned_nxt_s = 1'b1;
            state_nxt_s      = FLUSH;
          end
        end else begin
          pc_nxt_s = pc_plus4_s;
        end
      end
      FLUSH: begin
        state_nxt_s = FETCH;
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= BOOT;
      pc_r         <= RESET_VECTOR;
      epc_r        <= 32'd0;
      boot_cnt_r   <= 8'd0;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      epc_r        <= epc_nxt_s;
      boot_cnt_r   <= boot_cnt_nxt_s;
      misaligned_r <= misaligned_nxt_s;
    end
  end

  // The request follows the state directly so it drops the moment FETCH is left or reset asserts.
  assign bus.imem_req    = (state_r == FETCH);
  assign bus.instr_valid = advance_s;
  assign bus.pc_out      = pc_r;
  assign bus.pc_plus4    = pc_plus4_s;
  assign bus.misaligned  = misaligned_r;
  assign bus.epc_out     = epc_r;
  assign bus.state_out   = state_r;

endmodule
